// File: rtl/debounce_pkg.sv
// Shared types and default constants for the push-button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } db_state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/debounce_pulse_if.sv
// Button-side bundle: raw input in, debounced level/pulses/busy and FSM state out.
interface debounce_pulse_if;
    import debounce_pkg::*;

    logic      btn_raw;
    logic      level;
    logic      rise_pulse;
    logic      fall_pulse;
    logic      busy;
    db_state_t state;

    // btn_raw has no handshake: it is sampled every cycle; the outputs are
    // valid every cycle after reset, and rise/fall are single-cycle strobes.
    modport master (output btn_raw, input level, rise_pulse, fall_pulse, busy, state);
    modport slave  (input btn_raw, output level, rise_pulse, fall_pulse, busy, state);

endinterface

// File: rtl/sync_chain.sv
// N-flop synchroniser for one asynchronous bit, synchronous active-low reset to 0.
module sync_chain #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (N < 2) begin : g_bad_n
        $error("sync_chain needs at least two stages");
    end

    logic [N-1:0] ff;

    always_ff @(posedge clk) begin
        if (!reset) ff <= '0;
        else        ff <= {ff[N-2:0], d};
    end

    assign q = ff[N-1];

endmodule

// File: rtl/debounce_pulse.sv
// Debouncer: synchronise btn_raw, accept a level change after STABLE_CYCLES
// consecutive equal samples, and strobe rise/fall for one cycle on acceptance.
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    debounce_pulse_if.slave  bus
);

    localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    db_state_t        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             level, level_d;
    logic             rise, rise_d;
    logic             fall, fall_d;
    logic             busy, busy_d;

    sync_chain #(.N(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.btn_raw),
        .q     (s)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            level <= level_d;
            rise  <= rise_d;
            fall  <= fall_d;
            busy  <= busy_d;
        end
    end

    // cnt holds the number of consecutive candidate samples seen so far.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed from the transition and registered, so busy tracks
    // the registered state exactly and pulses last one cycle.
    always_comb begin
        level_d = level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        busy_d  = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
        if (state == WAIT_HIGH && state_d == IDLE_HIGH) begin
            level_d = 1'b1;
            rise_d  = 1'b1;
        end
        if (state == WAIT_LOW && state_d == IDLE_LOW) begin
            level_d = 1'b0;
            fall_d  = 1'b1;
        end
    end

    assign bus.level      = level;
    assign bus.rise_pulse = rise;
    assign bus.fall_pulse = fall;
    assign bus.busy       = busy;
    assign bus.state      = state;

endmodule

// File: tb/tb_debounce_pulse.sv
// Bench for debounce_pulse: directed cases plus random bouncing input,
// checked cycle by cycle against a history-based reference model.
module tb_debounce_pulse;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;

    logic clk;
    logic reset;

    debounce_pulse_if bus ();

    debounce_pulse #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset block
    initial begin
        clk         = 1'b0;
        reset       = 1'b0;
        bus.btn_raw = 1'b0;
    end
    always #5 clk = ~clk;

    // scoreboard: {level, rise_pulse, fall_pulse, busy}
    logic [3:0] exp_q[$];
    int tests       = 0;
    int fails       = 0;
    int exp_rises   = 0;
    int seen_rises  = 0;
    int cyc         = 0;

    // reference model state: raw samples in flight through the synchroniser,
    // and synced samples seen since the last accepted level change
    bit pipe[$];
    bit hist[$];
    bit m_level;

    task automatic model_reset();
        pipe = {};
        for (int i = 0; i < SYNC; i++) pipe.push_back(1'b0);
        hist    = {};
        m_level = 1'b0;
    endtask

    // Drive one cycle of stimulus and push the outputs expected after the edge.
    task automatic step(input bit r, input bit b);
        logic [3:0] e;
        bit         s;
        bit         rp;
        bit         fp;
        int         t;
        @(negedge clk);
        reset       = r;
        bus.btn_raw = b;
        rp = 1'b0;
        fp = 1'b0;
        t  = 0;
        if (!r) begin
            model_reset();
        end else begin
            s = pipe.pop_front();
            pipe.push_back(b);
            hist.push_back(s);
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] == m_level) break;
                t++;
            end
            if (t >= STABLE) begin
                m_level = ~m_level;
                rp      = m_level;
                fp      = ~m_level;
                hist    = {};
                t       = 0;
            end
        end
        e = {m_level, rp, fp, (t > 0)};
        if (rp) exp_rises++;
        exp_q.push_back(e);
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) step(1'b1, b);
    endtask

    // monitor: outputs are presented every cycle, compared #1 after the edge
    initial begin
        logic [3:0] got;
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                got = {bus.level, bus.rise_pulse, bus.fall_pulse, bus.busy};
                e   = exp_q.pop_front();
                tests++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL outputs cyc=%0d got lvl/rise/fall/busy=%b expected=%b",
                             cyc, got, e);
                end
                if (got[2] === 1'b1) seen_rises++;
            end
        end
    end

    initial begin
        model_reset();

        // reset held with button high
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

        // clean press, held
        hold(1'b1, 10);

        // release to low, then bouncing press
        hold(1'b0, 10);
        hold(1'b1, 3);
        hold(1'b0, 1);
        hold(1'b1, 12);

        // release from level high
        hold(1'b0, 12);

        // single-cycle glitch in idle
        hold(1'b1, 1);
        hold(1'b0, 8);

        // reset while qualifying a press, then press held through release
        hold(1'b1, 3);
        step(1'b0, 1'b1);
        hold(1'b1, 10);
        hold(1'b0, 10);

        // random bouncing runs with occasional resets
        for (int k = 0; k < 600; k++) begin
            bit b;
            int n;
            b = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 8);
            if ($urandom_range(0, 99) == 0) step(1'b0, b);
            hold(b, n);
        end

        // drain
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
        tests++;
        if (seen_rises != exp_rises) begin
            fails++;
            $display("FAIL rise_count got=%0d required=%0d", seen_rises, exp_rises);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
